conv_job_scheduler: RTL and testbench

CONV_JOB_SCHEDULER -- requirements
Module: conv_job_scheduler

---
 rtl/conv_job_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_conv_job_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_job_scheduler.sv
// Convolution job scheduler: round-robin arbitration of requesters for a single
// conv engine, descriptor validation, kernel then sample fetch from a shared
// buffer, and a drain wait for the engine pipeline before signalling completion.
module conv_job_scheduler #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_PE     = 16,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned DRAIN_CYC  = 18
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_base,
  input  logic [NUM_REQ*5-1:0]      req_klen,
  input  logic [NUM_REQ*ADDR_W-1:0] req_xlen,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        job_done,
  output logic                      job_err,
  output logic                      busy,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data,
  output logic [4:0]                active_pe_count,
  output logic                      kernel_load,
  output logic [DATA_WIDTH-1:0]     kernel_value,
  output logic [DATA_WIDTH-1:0]     x_in,
  output logic                      x_valid,
  input  logic                      y_valid,
  output logic [ADDR_W-1:0]         y_count
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Wide enough to hold klen + xlen without overflow.
  localparam int unsigned CntW = ((ADDR_W > 5) ? ADDR_W : 5) + 1;
  localparam int unsigned DrnW = $clog2(DRAIN_CYC + 1) + 1;

  typedef enum logic [2:0] {
    StIdle, StArb, StCheck, StLoadK, StStream, StDrain, StDone
  } state_e;

  state_e state_q, state_d;

  logic [NUM_REQ-1:0] grant_q;
  logic [IdxW-1:0]    last_grant_q;
  logic [ADDR_W-1:0]  base_q;
  logic [ADDR_W-1:0]  xlen_q;
  logic [4:0]         klen_q;
  logic               err_q;
  logic [CntW-1:0]    rd_cnt_q;
  logic [DrnW-1:0]    drain_q;
  logic [4:0]         active_pe_q;
  logic [ADDR_W-1:0]  y_count_q;
  logic               kernel_load_q;
  logic               x_valid_q;

  logic               win_found;
  logic [IdxW-1:0]    win_idx;
  logic [IdxW-1:0]    rr_cand;
  logic [NUM_REQ-1:0] win_onehot;
  logic [ADDR_W-1:0]  win_base;
  logic [ADDR_W-1:0]  win_xlen;
  logic [4:0]         win_klen;
  logic [CntW-1:0]    klen_ext;
  logic [CntW-1:0]    xlen_ext;
  logic [CntW-1:0]    last_k;
  logic [CntW-1:0]    last_x;
  logic               desc_bad;
  logic               drain_done;
  logic               in_job;

  // Round-robin search starting one past the previous winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_cand   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      rr_cand = IdxW'((32'(last_grant_q) + i) % NUM_REQ);
      if (!win_found && req[rr_cand]) begin
        win_found = 1'b1;
        win_idx   = rr_cand;
      end
    end
  end

  // Select the winning requester's descriptor and one-hot grant.
  always_comb begin
    win_onehot = '0;
    win_base   = '0;
    win_klen   = '0;
    win_xlen   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IdxW'(i) == win_idx) begin
        win_onehot[i] = win_found;
        win_base      = req_base[i*ADDR_W +: ADDR_W];
        win_klen      = req_klen[i*5 +: 5];
        win_xlen      = req_xlen[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign klen_ext   = CntW'(klen_q);
  assign xlen_ext   = CntW'(xlen_q);
  assign last_k     = klen_ext - CntW'(1);
  assign last_x     = klen_ext + xlen_ext - CntW'(1);
  assign desc_bad   = (klen_q == 5'd0) || (klen_ext > CntW'(NUM_PE)) || (xlen_ext < klen_ext);
  // A y_valid at or past the threshold keeps us waiting for the engine to go quiet.
  assign drain_done = (drain_q >= DrnW'(DRAIN_CYC)) && !y_valid;
  assign in_job     = (state_q == StLoadK) || (state_q == StStream) || (state_q == StDrain);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (|req) state_d = StArb;
      StArb:    state_d = win_found ? StCheck : StIdle;
      StCheck:  state_d = desc_bad ? StDone : StLoadK;
      StLoadK:  if (rd_cnt_q == last_k) state_d = StStream;
      StStream: if (rd_cnt_q == last_x) state_d = StDrain;
      StDrain:  if (drain_done) state_d = StDone;
      StDone:   state_d = (|req) ? StArb : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Job datapath: grant/descriptor latch, read counter, drain counter, y counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      grant_q       <= '0;
      last_grant_q  <= IdxW'(NUM_REQ - 1);
      base_q        <= '0;
      klen_q        <= '0;
      xlen_q        <= '0;
      err_q         <= 1'b0;
      rd_cnt_q      <= '0;
      drain_q       <= '0;
      active_pe_q   <= '0;
      y_count_q     <= '0;
      kernel_load_q <= 1'b0;
      x_valid_q     <= 1'b0;
    end else begin
      // Read data returns one cycle after the strobe, so the engine strobes lag by one.
      kernel_load_q <= (state_q == StLoadK);
      x_valid_q     <= (state_q == StStream);
      case (state_q)
        StArb: begin
          if (win_found) begin
            grant_q      <= win_onehot;
            last_grant_q <= win_idx;
            base_q       <= win_base;
            klen_q       <= win_klen;
            xlen_q       <= win_xlen;
          end
        end
        StCheck: begin
          rd_cnt_q <= '0;
          err_q    <= desc_bad;
          if (!desc_bad) begin
            active_pe_q <= klen_q;
            y_count_q   <= '0;
          end
        end
        StLoadK, StStream: begin
          rd_cnt_q <= rd_cnt_q + CntW'(1);
          drain_q  <= '0;
        end
        StDrain: begin
          if (drain_q < DrnW'(DRAIN_CYC)) drain_q <= drain_q + DrnW'(1);
        end
        StDone: begin
          grant_q <= '0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
      if (in_job && y_valid && (y_count_q != '1)) y_count_q <= y_count_q + ADDR_W'(1);
    end
  end

  assign grant           = grant_q;
  assign job_done        = (state_q == StDone) ? grant_q : '0;
  assign job_err         = (state_q == StDone) && err_q;
  assign busy            = (state_q != StIdle);
  assign mem_rd_en       = (state_q == StLoadK) || (state_q == StStream);
  // Addresses wrap naturally at 2^ADDR_W.
  assign mem_rd_addr     = mem_rd_en ? (base_q + rd_cnt_q[ADDR_W-1:0]) : '0;
  assign active_pe_count = active_pe_q;
  assign kernel_load     = kernel_load_q;
  assign kernel_value    = kernel_load_q ? mem_rd_data : '0;
  assign x_valid         = x_valid_q;
  assign x_in            = x_valid_q ? mem_rd_data : '0;
  assign y_count         = y_count_q;

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Bench for conv_job_scheduler: table of job descriptors with hand-set expected
// grants/errors, a scoreboard of expected reads/strobes/completions, plus
// hand-written reset-abort sequence.
module tb_conv_job_scheduler;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int AW = 6;
  localparam int DC = 18;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req;
  logic [NR*AW-1:0] req_base;
  logic [NR*5-1:0]  req_klen;
  logic [NR*AW-1:0] req_xlen;
  logic [NR-1:0]    grant;
  logic [NR-1:0]    job_done;
  logic             job_err;
  logic             busy;
  logic             mem_rd_en;
  logic [AW-1:0]    mem_rd_addr;
  logic [DW-1:0]    mem_rd_data;
  logic [4:0]       active_pe_count;
  logic             kernel_load;
  logic [DW-1:0]    kernel_value;
  logic [DW-1:0]    x_in;
  logic             x_valid;
  logic             y_valid;
  logic [AW-1:0]    y_count;

  always #5 clk = ~clk;

  conv_job_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .req_base        (req_base),
    .req_klen        (req_klen),
    .req_xlen        (req_xlen),
    .grant           (grant),
    .job_done        (job_done),
    .job_err         (job_err),
    .busy            (busy),
    .mem_rd_en       (mem_rd_en),
    .mem_rd_addr     (mem_rd_addr),
    .mem_rd_data     (mem_rd_data),
    .active_pe_count (active_pe_count),
    .kernel_load     (kernel_load),
    .kernel_value    (kernel_value),
    .x_in            (x_in),
    .x_valid         (x_valid),
    .y_valid         (y_valid),
    .y_count         (y_count)
  );

  function automatic logic [7:0] mem_fn(input logic [5:0] a);
    return {a, 2'b10} ^ 8'h5A;
  endfunction

  // Shared buffer model: data one cycle after the read strobe.
  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem_fn(mem_rd_addr) : 8'h00;

  typedef struct {
    logic [3:0] req;
    logic [5:0] base;
    logic [4:0] klen;
    logic [5:0] xlen;
    logic [3:0] exp_grant;
    logic       exp_err;
    bit         drop;
    bit         hold;
  } vec_t;

  typedef struct {
    logic [7:0] val;
    bit         is_x;
  } strobe_t;

  typedef struct {
    logic [3:0] grant;
    logic       err;
    int         drain;
    int         nstrobe;
  } done_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [5:0] exp_addr_q[$];
  strobe_t    exp_stream_q[$];
  done_t      done_q[$];

  bit prev_rd, ywin, grant_seen, after_done, xv_last, hold_en;
  int drain_idx, ycnt, ycnt_last, first_strobe, last_strobe, nstrobe, nx, done_cnt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic job_reset();
    ywin = 0; ycnt = 0; drain_idx = -1; prev_rd = 0; grant_seen = 0;
    first_strobe = -1; last_strobe = -1; nstrobe = 0; nx = 0;
  endtask

  task automatic monitor();
    strobe_t s;
    done_t d;
    cyc++;
    if (mem_rd_en) begin
      ywin = 1;
      if (exp_addr_q.size() == 0) check("rd_unexpected", 32'(mem_rd_en), 0);
      else check("rd_addr", 32'(mem_rd_addr), 32'(exp_addr_q.pop_front()));
    end
    if (ywin && y_valid && job_done == 0) ycnt++;
    if (drain_idx >= 0) drain_idx++;
    else if (prev_rd && !mem_rd_en) drain_idx = 0;
    prev_rd = mem_rd_en;
    if (kernel_load || x_valid) begin
      check("strobe_excl", 32'(kernel_load & x_valid), 0);
      if (exp_stream_q.size() == 0) check("strobe_unexpected", 32'(kernel_load | x_valid), 0);
      else begin
        s = exp_stream_q.pop_front();
        check("strobe_kind", 32'(x_valid), 32'(s.is_x));
        check("strobe_data", 32'(x_valid ? x_in : kernel_value), 32'(s.val));
      end
      if (first_strobe < 0) first_strobe = cyc;
      last_strobe = cyc;
      nstrobe++;
      if (x_valid) nx++;
    end
    if (after_done) begin
      check("grant_cleared", 32'(grant), 0);
      check("done_one_cycle", 32'(job_done), 0);
      after_done = 0;
    end
    if (grant != 0 && !grant_seen) begin
      grant_seen = 1;
      if (done_q.size() == 0) check("grant_unexpected", 32'(grant), 0);
      else check("grant", 32'(grant), 32'(done_q[0].grant));
    end
    if (job_done != 0) begin
      if (done_q.size() == 0) check("done_unexpected", 32'(job_done), 0);
      else begin
        d = done_q.pop_front();
        check("job_done", 32'(job_done), 32'(d.grant));
        check("job_err", 32'(job_err), 32'(d.err));
        check("grant_at_done", 32'(grant), 32'(d.grant));
        check("busy_at_done", 32'(busy), 1);
        check("drain_len", drain_idx, d.drain);
        check("strobe_count", nstrobe, d.nstrobe);
        if (d.nstrobe > 0) check("strobe_span", last_strobe - first_strobe + 1, d.nstrobe);
        if (d.err) check("y_count_held", 32'(y_count), ycnt_last);
        else begin
          ycnt_last = (ycnt > 63) ? 63 : ycnt;
          check("y_count", 32'(y_count), ycnt_last);
        end
      end
      done_cnt++;
      after_done = 1;
      job_reset();
    end else if (job_err) begin
      check("err_without_done", 32'(job_err), 0);
    end
    xv_last = x_valid;
  endtask

  // Inputs change just after the rising edge; outputs sampled on the falling edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    y_valid = xv_last | (hold_en && drain_idx >= 0 && drain_idx + 1 >= DC && drain_idx + 1 <= DC + 4);
    @(negedge clk);
    monitor();
  endtask

  task automatic drive(input vec_t v);
    req = v.req;
    for (int i = 0; i < NR; i++) begin
      req_base[i*AW +: AW] = v.base;
      req_klen[i*5 +: 5]   = v.klen;
      req_xlen[i*AW +: AW] = v.xlen;
    end
    hold_en = v.hold;
  endtask

  task automatic push_job(input vec_t v);
    done_t      d;
    strobe_t    s;
    logic [5:0] a;
    int         n;
    n = int'(v.klen) + int'(v.xlen);
    d.grant   = v.exp_grant;
    d.err     = v.exp_err;
    d.nstrobe = v.exp_err ? 0 : n;
    d.drain   = v.exp_err ? -1 : (v.hold ? DC + 6 : DC + 1);
    done_q.push_back(d);
    if (!v.exp_err) begin
      for (int i = 0; i < n; i++) begin
        a = v.base + 6'(i);
        exp_addr_q.push_back(a);
        s.val  = mem_fn(a);
        s.is_x = (i >= int'(v.klen));
        exp_stream_q.push_back(s);
      end
    end
  endtask

  task automatic run_job(input vec_t v);
    int start;
    drive(v);
    push_job(v);
    start = done_cnt;
    for (int t = 0; t < 400 && done_cnt == start; t++) begin
      cycle();
      if (v.drop && grant != 0) req = '0;
    end
    if (done_cnt == start) check("job_timeout", done_cnt - start, 1);
  endtask

  task automatic check_reset_vals();
    check("rst_grant", 32'(grant), 0);
    check("rst_job_done", 32'(job_done), 0);
    check("rst_job_err", 32'(job_err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rd_en", 32'(mem_rd_en), 0);
    check("rst_rd_addr", 32'(mem_rd_addr), 0);
    check("rst_pe_count", 32'(active_pe_count), 0);
    check("rst_kernel_load", 32'(kernel_load), 0);
    check("rst_kernel_value", 32'(kernel_value), 0);
    check("rst_x_in", 32'(x_in), 0);
    check("rst_x_valid", 32'(x_valid), 0);
    check("rst_y_count", 32'(y_count), 0);
  endtask

  vec_t vecs[11];
  vec_t rv;

  initial begin
    // req, base, klen, xlen, exp_grant, exp_err, drop req after grant, hold y in drain
    vecs[0]  = '{4'b0001, 6'd0,  5'd3,  6'd8,  4'b0001, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{4'b1111, 6'd5,  5'd2,  6'd4,  4'b0010, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{4'b1111, 6'd10, 5'd16, 6'd20, 4'b0100, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{4'b1111, 6'd0,  5'd1,  6'd1,  4'b1000, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{4'b1111, 6'd60, 5'd4,  6'd6,  4'b0001, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'b0100, 6'd0,  5'd0,  6'd5,  4'b0100, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{4'b0100, 6'd0,  5'd17, 6'd30, 4'b0100, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{4'b0100, 6'd0,  5'd4,  6'd2,  4'b0100, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{4'b0010, 6'd3,  5'd5,  6'd5,  4'b0010, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{4'b1001, 6'd20, 5'd2,  6'd3,  4'b1000, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{4'b1001, 6'd1,  5'd2,  6'd3,  4'b0001, 1'b0, 1'b0, 1'b0};

    reset = 1'b0; req = '0; req_base = '0; req_klen = '0; req_xlen = '0;
    y_valid = 1'b0; xv_last = 0; hold_en = 0; after_done = 0;
    done_cnt = 0; ycnt_last = 0;
    job_reset();

    cycle();
    cycle();
    check_reset_vals();
    reset = 1'b1;
    cycle();
    check("idle_busy", 32'(busy), 0);

    for (int k = 0; k < 11; k++) run_job(vecs[k]);
    req = '0;
    cycle();
    cycle();
    check("idle_after_jobs", 32'(busy), 0);
    check("pe_count_last", 32'(active_pe_count), 2);

    // Abort a job partway through streaming.
    rv = '{4'b0001, 6'd0, 5'd3, 6'd8, 4'b0001, 1'b0, 1'b0, 1'b0};
    drive(rv);
    push_job(rv);
    for (int t = 0; t < 100 && nx < 3; t++) cycle();
    check("abort_reached_stream", nx, 3);
    reset = 1'b0;
    req = '0;
    exp_addr_q.delete();
    exp_stream_q.delete();
    done_q.delete();
    job_reset();
    after_done = 0;
    ycnt_last = 0;
    cycle();
    check_reset_vals();
    reset = 1'b1;
    for (int t = 0; t < 3; t++) cycle();
    check("post_abort_idle", 32'(busy), 0);
    check("post_abort_no_done", done_cnt, 11);

    // Fresh arbitration after reset favours requester 0.
    run_job('{4'b1111, 6'd8, 5'd2, 6'd5, 4'b0001, 1'b0, 1'b0, 1'b0});
    req = '0;
    cycle();
    cycle();

    check("sb_empty", exp_addr_q.size() + exp_stream_q.size() + done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
